stage_reg: RTL



---
 rtl/stage_reg_pkg.sv | 20 ++
 rtl/stage_reg_exc_merge.sv | 22 ++
 rtl/stage_reg.sv | 118 +++++++++++
 3 files changed

// File: rtl/stage_reg_pkg.sv
// Shared constants for the pipeline stage registers: exception codes,
// default reset PC and T_new encodings per instruction class.
// Pure declarations; no logic, no latency, no flow control.
package stage_reg_pkg;

  // Default PC after reset and flush (boot vector).
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // ExcCode values. Code 0 doubles as "no exception" inside the pipe.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // T_new at the D/E boundary per instruction class.
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/stage_reg_exc_merge.sv
// Exception priority merge: earlier-stage code wins over the local one.
// Combinational, zero latency; no flow control.
// Ports: valid_in, exc_in, exc_local -> exc_merged (0 when invalid), kill.
module stage_reg_exc_merge #(
  parameter int EXC_W = 5
) (
  input  logic             valid_in,
  input  logic [EXC_W-1:0] exc_in,
  input  logic [EXC_W-1:0] exc_local,
  output logic [EXC_W-1:0] exc_merged,
  output logic             kill
);

  logic [EXC_W-1:0] exc_sel;

  // An exception raised upstream is older than one raised here.
  assign exc_sel    = (exc_in != '0) ? exc_in : exc_local;
  assign exc_merged = valid_in ? exc_sel : '0;
  // kill: a valid instruction carries an exception and must not retire.
  assign kill       = valid_in && (exc_sel != '0);

endmodule

// File: rtl/stage_reg.sv
// Pipeline stage register with hazard/exception fields; priority
// reset > flush > hold > bubble > load. Latency 1 cycle, fwd_ok comb.
// Backpressure: hold freezes every field; bubble empties but keeps PC/BD.
// Ports: clk, reset, flush, hold, bubble; *_in captured to *_out;
//        exc_in/exc_local merged to exc_out; fwd_ok = forwarding source valid.
module stage_reg
  import stage_reg_pkg::*;
#(
  parameter int          PAYLOAD_W = 96,
  parameter int          EXC_W     = 5,
  parameter int          TNEW_W    = 2,
  parameter bit          DEC_TNEW  = 1'b1,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 hold,
  input  logic                 bubble,
  input  logic                 valid_in,
  input  logic [31:0]          pc_in,
  input  logic                 bd_in,
  input  logic [EXC_W-1:0]     exc_in,
  input  logic [EXC_W-1:0]     exc_local,
  input  logic [TNEW_W-1:0]    tnew_in,
  input  logic [4:0]           a3_in,
  input  logic                 we_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  output logic [31:0]          pc_out,
  output logic                 bd_out,
  output logic [EXC_W-1:0]     exc_out,
  output logic [TNEW_W-1:0]    tnew_out,
  output logic [4:0]           a3_out,
  output logic                 we_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic                 fwd_ok
);

  logic                 valid_q, bd_q, we_q;
  logic [31:0]          pc_q;
  logic [EXC_W-1:0]     exc_q;
  logic [TNEW_W-1:0]    tnew_q;
  logic [4:0]           a3_q;
  logic [PAYLOAD_W-1:0] payload_q;

  logic [EXC_W-1:0]     exc_d;
  logic                 kill;
  logic                 we_d;
  logic [4:0]           a3_d;
  logic [TNEW_W-1:0]    tnew_d;

  stage_reg_exc_merge #(.EXC_W(EXC_W)) u_exc_merge (
    .valid_in  (valid_in),
    .exc_in    (exc_in),
    .exc_local (exc_local),
    .exc_merged(exc_d),
    .kill      (kill)
  );

  // Excepting instructions never write the GRF; a3 is zeroed whenever no
  // write happens so the hazard unit can compare a3 alone.
  assign we_d = we_in && valid_in && !kill;
  assign a3_d = we_d ? a3_in : 5'd0;

  generate
    if (DEC_TNEW) begin : g_dec
      assign tnew_d = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);
    end else begin : g_pass
      assign tnew_d = tnew_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      bd_q      <= 1'b0;
      exc_q     <= '0;
      tnew_q    <= '0;
      a3_q      <= '0;
      we_q      <= 1'b0;
      payload_q <= '0;
    end else if (hold) begin
      // Freeze: every register keeps its value.
    end else if (bubble || !valid_in) begin
      // PC/BD still advance so EPC stays correct across a stall.
      valid_q   <= 1'b0;
      pc_q      <= pc_in;
      bd_q      <= bd_in;
      exc_q     <= '0;
      tnew_q    <= '0;
      a3_q      <= '0;
      we_q      <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= 1'b1;
      pc_q      <= pc_in;
      bd_q      <= bd_in;
      exc_q     <= exc_d;
      tnew_q    <= tnew_d;
      a3_q      <= a3_d;
      we_q      <= we_d;
      payload_q <= payload_in;
    end
  end

  assign valid_out   = valid_q;
  assign pc_out      = pc_q;
  assign bd_out      = bd_q;
  assign exc_out     = exc_q;
  assign tnew_out    = tnew_q;
  assign a3_out      = a3_q;
  assign we_out      = we_q;
  assign payload_out = payload_q;
  assign fwd_ok      = valid_q && we_q && (a3_q != 5'd0) && (tnew_q == '0);

endmodule
